candy_1007: RTL and testbench



---
 rtl/candy_pkg.sv | 32 +++
 rtl/candy_1007.sv | 78 +++++++
 tb/tb_candy_1007.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/candy_pkg.sv
// Shared constants for the candy vending controller: state encodings,
// coin codes and small decode helpers used by the controller.
package candy_pkg;

    localparam logic [2:0] S0  = 3'b000;
    localparam logic [2:0] S5  = 3'b001;
    localparam logic [2:0] S10 = 3'b010;
    localparam logic [2:0] S15 = 3'b011;
    localparam logic [2:0] S20 = 3'b100;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    // Dispense is asserted only in the two states where credit reached the price.
    function automatic logic is_dispense(input logic [2:0] st);
        logic hit;
        case (st)
            S15:     hit = 1'b1;
            S20:     hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Even parity over a state code, handy for observation/debug checkers.
    function automatic logic state_parity(input logic [2:0] st);
        return ^st;
    endfunction

endpackage

// File: rtl/candy_1007.sv
// Moore candy vending controller: accumulates 5/10 unit coins toward a
// 15 unit price and strobes `out` for each candy, carrying a 5 unit overpay.
module candy_1007
    import candy_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] in,
    output logic       out,
    output logic [2:0] pre_s,
    output logic [2:0] next_s
);

    // State register; reset wins over any coin presented in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_s <= S0;
        end else begin
            pre_s <= next_s;
        end
    end

    // Next-state logic; dispense states first consume the price, then add the coin.
    always_comb begin
        next_s = S0;
        case (pre_s)
            S0: begin
                case (in)
                    COIN_5:  next_s = S5;
                    COIN_10: next_s = S10;
                    default: next_s = S0;
                endcase
            end
            S5: begin
                case (in)
                    COIN_5:  next_s = S10;
                    COIN_10: next_s = S15;
                    default: next_s = S5;
                endcase
            end
            S10: begin
                case (in)
                    COIN_5:  next_s = S15;
                    COIN_10: next_s = S20;
                    default: next_s = S10;
                endcase
            end
            S15: begin
                case (in)
                    COIN_5:  next_s = S5;
                    COIN_10: next_s = S10;
                    default: next_s = S0;
                endcase
            end
            S20: begin
                case (in)
                    COIN_5:  next_s = S10;
                    COIN_10: next_s = S15;
                    default: next_s = S5;
                endcase
            end
            default: begin
                next_s = S0;
            end
        endcase
    end

    // Moore output: decoded from the registered state only; illegal codes give 0.
    always_comb begin
        out = 1'b0;
        if (is_dispense(pre_s)) begin
            out = 1'b1;
        end else begin
            out = 1'b0;
        end
    end

endmodule

// File: tb/tb_candy_1007.sv
// Self-checking bench for candy_1007: directed scenarios plus randomized
// coins checked against a credit-arithmetic reference model.
module tb_candy_1007;

    logic       clk;
    logic       reset;
    logic [1:0] coin;
    logic       dout;
    logic [2:0] pre_s;
    logic [2:0] next_s;

    int errors = 0;
    int checks = 0;

    candy_1007 dut (
        .clk    (clk),
        .reset  (reset),
        .in     (coin),
        .out    (dout),
        .pre_s  (pre_s),
        .next_s (next_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: credit in units, state code is credit/5.
    function automatic int coin_val(input logic [1:0] c);
        if (c == 2'b01) return 5;
        if (c == 2'b10) return 10;
        return 0;
    endfunction

    function automatic int next_credit(input int cr, input logic [1:0] c);
        int base;
        base = (cr >= 15) ? cr - 15 : cr;
        return base + coin_val(c);
    endfunction

    task automatic tick(input logic [1:0] c, input logic r);
        coin  = c;
        reset = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            tick(2'b00, 1'b1);
            checks++;
            if (pre_s !== 3'b000 || dout !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: pre_s=%b out=%b expected pre_s=000 out=0", i, pre_s, dout);
            end
        end
        tick(2'b00, 1'b0);
        checks++;
        if (pre_s !== 3'b000 || dout !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: pre_s=%b out=%b expected pre_s=000 out=0", pre_s, dout);
        end
    endtask

    // Runs a coin sequence from S0 and compares against fixed expectations.
    task automatic test_sequence(input string name, input int n,
                                 input logic [1:0] cs [8], input logic [2:0] es [8],
                                 input logic eo [8]);
        tick(2'b00, 1'b1);
        for (int i = 0; i < n; i++) begin
            tick(cs[i], 1'b0);
            checks++;
            if (pre_s !== es[i] || dout !== eo[i]) begin
                errors++;
                $display("FAIL %s step %0d: pre_s=%b out=%b expected pre_s=%b out=%b",
                         name, i, pre_s, dout, es[i], eo[i]);
            end
        end
    endtask

    task automatic test_directed();
        logic [1:0] cs [8];
        logic [2:0] es [8];
        logic       eo [8];
        cs = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00};
        es = '{3'b000, 3'b001, 3'b011, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
        eo = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        test_sequence("seq_mixed", 5, cs, es, eo);
        cs = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        es = '{3'b010, 3'b100, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
        eo = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        test_sequence("seq_carry", 3, cs, es, eo);
        cs = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        es = '{3'b001, 3'b010, 3'b011, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
        eo = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        test_sequence("seq_exact", 4, cs, es, eo);
        cs = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        es = '{3'b010, 3'b100, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        eo = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        test_sequence("seq_double_dispense", 4, cs, es, eo);
    endtask

    task automatic test_bad_coin();
        logic [1:0] c1 [5];
        logic [1:0] c2 [5];
        logic [2:0] reach [5];
        logic [2:0] after [5];
        c1    = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
        c2    = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10};
        reach = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
        after = '{3'b000, 3'b001, 3'b010, 3'b000, 3'b001};
        for (int i = 0; i < 5; i++) begin
            tick(2'b00, 1'b1);
            tick(c1[i], 1'b0);
            tick(c2[i], 1'b0);
            checks++;
            if (pre_s !== reach[i]) begin
                errors++;
                $display("FAIL bad_coin_reach %0d: pre_s=%b expected %b", i, pre_s, reach[i]);
            end
            coin = 2'b11;
            #1;
            checks++;
            if (next_s !== after[i]) begin
                errors++;
                $display("FAIL bad_coin_next %0d: next_s=%b expected %b", i, next_s, after[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (pre_s !== after[i] || dout !== 1'b0) begin
                errors++;
                $display("FAIL bad_coin_state %0d: pre_s=%b out=%b expected pre_s=%b out=0",
                         i, pre_s, dout, after[i]);
            end
        end
    endtask

    task automatic test_reset_priority();
        tick(2'b00, 1'b1);
        tick(2'b10, 1'b0);
        coin  = 2'b10;
        reset = 1'b1;
        #1;
        checks++;
        if (next_s !== 3'b100) begin
            errors++;
            $display("FAIL reset_prio_next: next_s=%b expected 100", next_s);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pre_s !== 3'b000 || dout !== 1'b0) begin
            errors++;
            $display("FAIL reset_prio_state: pre_s=%b out=%b expected pre_s=000 out=0", pre_s, dout);
        end
        tick(2'b01, 1'b0);
        tick(2'b10, 1'b0);
        checks++;
        if (dout !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_dispense_pre: out=%b expected 1", dout);
        end
        tick(2'b10, 1'b1);
        checks++;
        if (pre_s !== 3'b000 || dout !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_dispense: pre_s=%b out=%b expected pre_s=000 out=0", pre_s, dout);
        end
    endtask

    task automatic test_random();
        int         credit;
        int         nc;
        logic [1:0] c;
        logic       r;
        tick(2'b00, 1'b1);
        credit = 0;
        for (int i = 0; i < 400; i++) begin
            c = 2'($urandom_range(0, 3));
            r = ($urandom_range(0, 19) == 0);
            coin  = c;
            reset = r;
            nc = next_credit(credit, c);
            #1;
            checks++;
            if (next_s !== 3'(nc / 5)) begin
                errors++;
                $display("FAIL rand_next %0d: next_s=%b expected %b", i, next_s, 3'(nc / 5));
            end
            @(posedge clk);
            #1;
            credit = r ? 0 : nc;
            checks++;
            if (pre_s !== 3'(credit / 5) || dout !== (credit >= 15)) begin
                errors++;
                $display("FAIL rand_state %0d: pre_s=%b out=%b expected pre_s=%b out=%b",
                         i, pre_s, dout, 3'(credit / 5), (credit >= 15));
            end
        end
    endtask

    initial begin
        coin  = 2'b00;
        reset = 1'b1;
        test_reset();
        test_directed();
        test_bad_coin();
        test_reset_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
